// File: rtl/seq_add32_if.sv
// Operand/result handshake bundle for the multi-cycle adder/subtractor sequencer.
// The slave side is the sequencer; the master side is the operand producer and result consumer.
interface seq_add32_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_result;
   logic             cout;
   logic             overflow;

   modport master (
      output in_valid, data_operandA, data_operandB, sub, out_ready,
      input  in_ready, out_valid, data_result, cout, overflow
   );

   modport slave (
      input  in_valid, data_operandA, data_operandB, sub, out_ready,
      output in_ready, out_valid, data_result, cout, overflow
   );
endinterface

// File: rtl/seq_add32.sv
// Multi-cycle WIDTH-bit adder/subtractor: one SLICE-bit carry-select slice is reused
// once per cycle, LSB slice first, with the carry chained through a 1-bit register.
module csel_add_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);
   localparam int LO = W / 2;
   localparam int HI = W - LO;

   logic [LO:0] lo_sum;
   logic [HI:0] hi_sum0;
   logic [HI:0] hi_sum1;

   // Upper half is precomputed for both carry-ins; the lower half's carry picks one.
   assign lo_sum  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
   assign hi_sum0 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
   assign hi_sum1 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]} + {{HI{1'b0}}, 1'b1};

   assign sum[LO-1:0]       = lo_sum[LO-1:0];
   assign {cout, sum[W-1:LO]} = lo_sum[LO] ? hi_sum1 : hi_sum0;
endmodule

module seq_add32 #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input logic        clock,
   input logic        reset,
   seq_add32_if.slave bus
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   state_e             state_q,  state_d;
   logic [WIDTH-1:0]   a_q,      a_d;
   logic [WIDTH-1:0]   b_q,      b_d;
   logic               carry_q,  carry_d;
   logic [IDX_W-1:0]   idx_q,    idx_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q,   cout_d;
   logic               ovf_q,    ovf_d;

   logic [SLICE-1:0]   sl_a;
   logic [SLICE-1:0]   sl_b;
   logic [SLICE-1:0]   sl_sum;
   logic               sl_cout;

   assign sl_a = a_q[idx_q*SLICE +: SLICE];
   assign sl_b = b_q[idx_q*SLICE +: SLICE];

   csel_add_slice #(.W(SLICE)) u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry_q),
      .sum  (sl_sum),
      .cout (sl_cout)
   );

   always_comb begin
      // NOTE: every _d starts from its held value, so no branch can infer a latch.
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
               a_d     = bus.data_operandA;
               b_d     = bus.data_operandB ^ {WIDTH{bus.sub}};
               carry_d = bus.sub;
               idx_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            result_d[idx_q*SLICE +: SLICE] = sl_sum;
            carry_d = sl_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NSLICE - 1)) begin
               cout_d  = sl_cout;
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_sum[SLICE-1] != a_q[WIDTH-1]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = (state_q == DONE);
   assign bus.data_result = result_q;
   assign bus.cout        = cout_q;
   assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_add32.sv
// Directed bench for seq_add32: hand-computed vectors, latency, backpressure,
// mid-operation reset and back-to-back handshakes.
module tb_seq_add32;
   localparam int NSLICE = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   seq_add32_if #(.WIDTH(32)) bus ();

   seq_add32 #(.WIDTH(32), .SLICE(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [31:0] exp_r,
                                input logic exp_c, input logic exp_o);
      check({tag, ".valid"},    32'(bus.out_valid),  32'd1);
      check({tag, ".result"},   bus.data_result,     exp_r);
      check({tag, ".cout"},     32'(bus.cout),       32'(exp_c));
      check({tag, ".overflow"}, 32'(bus.overflow),   32'(exp_o));
   endtask

   // Full operation with out_ready low until the result appears.
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] exp_r,
                        input logic exp_c, input logic exp_o);
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.sub           = s;
      bus.in_valid      = 1'b1;
      bus.out_ready     = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      check({tag, ".busy_ready"}, 32'(bus.in_ready), 32'd0);
      repeat (NSLICE - 1) tick();
      check({tag, ".early_valid"}, 32'(bus.out_valid), 32'd0);
      tick();
      check_outputs(tag, exp_r, exp_c, exp_o);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, ".drop_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, ".idle_ready"}, 32'(bus.in_ready),  32'd1);
   endtask

   initial begin
      bus.in_valid      = 1'b0;
      bus.out_ready     = 1'b0;
      bus.sub           = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;

      // Reset state
      tick();
      tick();
      check("rst.in_ready",  32'(bus.in_ready),  32'd1);
      check("rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("rst.result",    bus.data_result,    32'd0);
      check("rst.cout",      32'(bus.cout),      32'd0);
      check("rst.overflow",  32'(bus.overflow),  32'd0);
      reset = 1'b0;

      // Additions
      do_op("add_ff_1",    32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
      do_op("add_maxpos",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
      do_op("add_wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
      do_op("add_chain",   32'h89ABCDEF, 32'h76543211, 1'b0, 32'h00000000, 1'b1, 1'b0);

      // Subtractions
      do_op("sub_5_7",     32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
      do_op("sub_minneg",  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
      do_op("sub_zero",    32'h12345678, 32'h00000000, 1'b1, 32'h12345678, 1'b1, 1'b0);
      do_op("sub_0_min",   32'h00000000, 32'h80000000, 1'b1, 32'h80000000, 1'b0, 1'b1);
      do_op("sub_borrow",  32'h00010000, 32'h00000001, 1'b1, 32'h0000FFFF, 1'b1, 1'b0);

      // Backpressure; operands also change during BUSY and must be ignored
      bus.data_operandA = 32'h12345678;
      bus.data_operandB = 32'h11111111;
      bus.sub           = 1'b0;
      bus.in_valid      = 1'b1;
      tick();
      bus.in_valid      = 1'b0;
      bus.data_operandA = 32'hDEADBEEF;
      bus.data_operandB = 32'hFFFFFFFF;
      bus.sub           = 1'b1;
      repeat (NSLICE) tick();
      check_outputs("bp.done", 32'h23456789, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = (i != 1);
         tick();
         check("bp.hold_valid",  32'(bus.out_valid), 32'd1);
         check("bp.hold_ready",  32'(bus.in_ready),  32'd0);
         check("bp.hold_result", bus.data_result,    32'h23456789);
      end
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("bp.release_ready",  32'(bus.in_ready),  32'd1);
      check("bp.release_valid",  32'(bus.out_valid), 32'd0);
      check("bp.result_kept",    bus.data_result,    32'h23456789);
      tick();
      check("bp.no_accept",      32'(bus.in_ready),  32'd1);

      // Reset in the second BUSY cycle
      bus.data_operandA = 32'hAAAAAAAA;
      bus.data_operandB = 32'h55555555;
      bus.sub           = 1'b0;
      bus.in_valid      = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst.in_ready",  32'(bus.in_ready),  32'd1);
      check("mid_rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst.result",    bus.data_result,    32'd0);
      check("mid_rst.cout",      32'(bus.cout),      32'd0);
      repeat (NSLICE) tick();
      check("mid_rst.no_result", 32'(bus.out_valid), 32'd0);
      do_op("after_rst", 32'd3, 32'd4, 1'b0, 32'h00000007, 1'b0, 1'b0);

      // Back-to-back with in_valid and out_ready held high
      bus.data_operandA = 32'd1;
      bus.data_operandB = 32'd1;
      bus.sub           = 1'b0;
      bus.in_valid      = 1'b1;
      bus.out_ready     = 1'b1;
      tick();
      bus.data_operandA = 32'd2;
      bus.data_operandB = 32'd2;
      check("b2b.first_busy", 32'(bus.in_ready), 32'd0);
      repeat (NSLICE - 1) tick();
      check("b2b.first_early", 32'(bus.out_valid), 32'd0);
      tick();
      check_outputs("b2b.first", 32'd2, 1'b0, 1'b0);
      tick();
      check("b2b.done_1cycle", 32'(bus.out_valid), 32'd0);
      check("b2b.idle_ready",  32'(bus.in_ready),  32'd1);
      tick();
      check("b2b.second_accept", 32'(bus.in_ready), 32'd0);
      repeat (NSLICE - 1) tick();
      check("b2b.second_early", 32'(bus.out_valid), 32'd0);
      tick();
      check_outputs("b2b.second", 32'd4, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      tick();
      bus.out_ready = 1'b0;
      check("b2b.end_valid", 32'(bus.out_valid), 32'd0);
      check("b2b.end_ready", 32'(bus.in_ready),  32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/seq_add32.md
Name: seq_add32

Overview:
- Multi-cycle 32-bit adder/subtractor sequencer.
- Sits directly upstream of the team's 8-bit carry-select adder slice and owns one instance of it.
- Accepts a 32-bit operand pair, then feeds the slice one byte per cycle (LSB byte first), chaining the carry through a register.
- Returns the 32-bit result with carry-out and signed overflow over a valid/ready handshake.
- Used where area matters more than latency (ALU multi-cycle path).

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; equals the adder slice width.
- NSLICE, WIDTH/SLICE (=4), derived; number of slice cycles per operation.

Ports:
- clock  input  1  single clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands.
- data_operandA  input  WIDTH  operand A.
- data_operandB  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B; sampled with the operands.
- out_valid  output  1  result registers hold a completed operation.
- out_ready  input  1  consumer accepts the result.
- data_result  output  WIDTH  sum/difference.
- cout  output  1  carry out of the MSB; for subtraction, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Clock/reset: one clock (clock); reset is synchronous and active-high.
- Reset (sampled at a rising edge, overrides everything):
  - state=IDLE; in_ready=1; out_valid=0.
  - data_result=0, cout=0, overflow=0.
  - slice index=0, carry register=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch A, B'=B XOR {WIDTH{sub}}, carry=sub, index=0, then go to BUSY.
  - Operands are not sampled at any other time.
- BUSY:
  - in_ready=0.
  - Each cycle, drive the slice with A[8k+7:8k], B'[8k+7:8k] and the carry register (k = index).
  - Store the slice sum into data_result byte k; store the slice carry-out into the carry register.
  - index increments.
  - On k=NSLICE−1:
    - cout ← slice carry-out.
    - overflow ← (A[31]==B'[31]) && (sum[31]!=A[31]).
    - Go to DONE.
- DONE:
  - out_valid=1; in_ready=0.
  - data_result, cout and overflow are held stable while out_ready=0.
  - On out_ready=1, go to IDLE, out_valid drops the next cycle.
  - An in_valid in that same cycle is ignored, because in_ready=0.
- Latency: accept edge t → out_valid high after edge t+NSLICE (4 cycles). Throughput is at most one operation per NSLICE+2 cycles.
- Output visibility:
  - data_result bytes update progressively during BUSY; they are only meaningful while out_valid=1.
  - data_result is not cleared on DONE→IDLE.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - No sign-extension.
  - The carry register is 1 bit.
- Boundary conditions:
  - in_valid held high continuously: exactly one accept per IDLE visit.
  - out_ready held high continuously: DONE lasts exactly 1 cycle.
  - Reset in BUSY or DONE aborts the operation; no partial result is reported.
  - Operand inputs changing during BUSY have no effect.
  - sub=1 with B=0: result=A, cout=1, overflow=0.
  - sub=1 with B=0x80000000: follows the same overflow rule (A=0 gives overflow=1).

Test Plan:
- Add, A=0x000000FF, B=0x00000001, sub=0 → data_result=0x00000100, cout=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge, and the carry crosses the byte-0/byte-1 boundary.
- Add, A=0x7FFFFFFF, B=0x00000001 → 0x80000000, cout=0, overflow=1. Then A=0xFFFFFFFF, B=0x00000001 → 0x00000000, cout=1, overflow=0.
- Sub, A=5, B=7 → 0xFFFFFFFE, cout=0, overflow=0. Then A=0x80000000, B=1 → 0x7FFFFFFF, cout=1, overflow=1.
- Backpressure: complete 0x12345678+0x11111111, hold out_ready=0 for 3 cycles while pulsing in_valid → data_result=0x23456789 stays stable, in_ready=0, no new accept. out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-operation: accept 0xAAAAAAAA+0x55555555, assert reset in the 2nd BUSY cycle → next cycle state IDLE, in_ready=1, out_valid=0, data_result=0. A following 3+4 → 0x00000007 after 4 cycles.
- Back-to-back: in_valid and out_ready tied high, issue 1+1 then 2+2 → results 2 and 4. The second accept occurs exactly NSLICE+2 cycles after the first.
